seq_det_prog: RTL and testbench

Programmable serial pattern detector: the parametrised successor to the team's fixed 7-bit Moore sequence detector. It compares a runtime-loaded pattern of 1..MAX_LEN bits against a qualified serial bit stream and emits a registered one-cycle `flag` per match. Overlapping or non-overlapping detection is selectable, and a saturating match counter is included. It sits between a serial front end (deserialiser or line sampler) and control logic that counts or reacts to framing or sync words.

---
 rtl/seq_det_prog.sv | 115 +++++++++++
 tb/tb_seq_det_prog.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_prog
// Description : Programmable serial pattern detector with overlap control
//               and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_prog #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               seq_in,
  input  logic               cnt_clr,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   c_one_ext  = (LEN_W+1)'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [MAX_LEN-1:0] r_act_pat;
  logic [LEN_W-1:0]   r_act_len;
  logic               r_act_ovl;
  // The oldest history bit is never compared (matching looks at the
  // next-state history), so only MAX_LEN-1 bits are stored.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_flag;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;

  logic               w_len_ok;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_pat_eq;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_base;

  assign w_len_ok   = (r_act_len != '0) && (r_act_len <= c_max_len);
  assign w_shift    = in_valid && !cfg_load;
  assign w_hist_nxt = {r_hist, seq_in};

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign w_mask[gi] = (r_act_len > LEN_W'(gi));
    end
  endgenerate

  assign w_fill_ok  = ({1'b0, r_fill} + c_one_ext) >= {1'b0, r_act_len};
  assign w_pat_eq   = ((w_hist_nxt ^ r_act_pat) & w_mask) == '0;
  assign w_match    = w_shift && w_len_ok && w_fill_ok && w_pat_eq;
  assign w_cnt_base = cnt_clr ? '0 : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_pat <= '0;
      r_act_len <= '0;
      r_act_ovl <= 1'b1;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (cfg_load) begin
      r_act_pat <= cfg_pattern;
      r_act_len <= cfg_len;
      r_act_ovl <= cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (in_valid) begin
      r_hist <= w_hist_nxt[MAX_LEN-2:0];
      // Non-overlap restarts the fill count so matched bits cannot be reused.
      if (w_match && !r_act_ovl) begin
        r_fill <= '0;
      end else if (r_fill != c_max_len) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_flag <= w_match;
      if (w_match && (w_cnt_base != c_cnt_max)) begin
        r_cnt <= w_cnt_base + c_cnt_one;
      end else begin
        r_cnt <= w_cnt_base;
      end
      r_sat <= (r_sat && !cnt_clr) ||
               (w_match && (w_cnt_base == (c_cnt_max - c_cnt_one)));
    end
  end

  assign flag      = r_flag;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
  assign cfg_err   = !w_len_ok;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_prog
// Description : Self-checking bench for seq_det_prog (tables, corner cases,
//               randomized traffic against a bit-queue reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_TOP = 15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               seq_in = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               flag;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
  logic               cfg_err;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .seq_in(seq_in), .cnt_clr(cnt_clr), .flag(flag), .match_cnt(match_cnt),
    .cnt_sat(cnt_sat), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Reference model: the bits received since the last load (or last
  // non-overlapping match), compared directly against the pattern.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 q[$];
  int                 m_cnt;
  bit                 m_sat;
  bit                 m_flag;

  typedef struct {
    logic ld; logic [15:0] pat; logic [4:0] len; logic ovl;
    logic v; logic d; logic clr;
    logic ef; logic [3:0] ec; logic ee;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic ld, logic [15:0] pat, logic [4:0] len,
                              logic ovl, logic v, logic d, logic clr,
                              logic ef, logic [3:0] ec, logic ee);
    vec_t r;
    r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl; r.v = v; r.d = d;
    r.clr = clr; r.ef = ef; r.ec = ec; r.ee = ee;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(int len);
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

  task automatic model_reset();
    m_pat = '0; m_len = 0; m_ovl = 1; q.delete();
    m_cnt = 0; m_sat = 0; m_flag = 0;
  endtask

  task automatic model_step(input logic ld, input logic [15:0] pat,
                            input logic [4:0] len, input logic ovl,
                            input logic v, input logic d, input logic clr);
    bit match;
    match = 0;
    if (ld) begin
      m_pat = pat; m_len = int'(len); m_ovl = ovl; q.delete();
    end else if (v) begin
      q.push_back(d);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (legal(m_len) && q.size() >= m_len) begin
        match = 1;
        for (int k = 0; k < m_len; k++)
          if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) match = 0;
      end
      if (match && !m_ovl) q.delete();
    end
    m_flag = match;
    if (clr) begin m_cnt = 0; m_sat = 0; end
    if (match && m_cnt < CNT_TOP) m_cnt++;
    if (m_cnt == CNT_TOP) m_sat = 1;
  endtask

  task automatic step(input logic ld, input logic [15:0] pat, input logic [4:0] len,
                      input logic ovl, input logic v, input logic d, input logic clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = v; seq_in = d; cnt_clr = clr;
    @(posedge clk);
    model_step(ld, pat, len, ovl, v, d, clr);
    #1;
    check("flag", int'(flag), int'(m_flag));
    check("match_cnt", int'(match_cnt), m_cnt);
    check("cnt_sat", int'(cnt_sat), int'(m_sat));
    check("cfg_err", int'(cfg_err), int'(!legal(m_len)));
    if (flag) pulses++;
    cfg_load = 0; in_valid = 0; cnt_clr = 0;
  endtask

  task automatic bit_in(input logic d);
    step(1'b0, '0, '0, 1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    logic [11:0] s;
    logic [15:0] p;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_flag", int'(flag), 0);
    check("reset_cnt", int'(match_cnt), 0);
    check("reset_sat", int'(cnt_sat), 0);
    check("reset_err", int'(cfg_err), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Legacy pattern: overlapping then non-overlapping detection.
    s = 12'b1011_0101_1010;
    tbl.push_back(mk(1, 16'h005A, 5'd7, 1, 0, 0, 0, 0, 4'd0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, 16'h0, 5'd0, 0, 1, s[11-i], 0, (i == 6 || i == 11),
                       (i < 6) ? 4'd0 : (i < 11) ? 4'd1 : 4'd2, 0));
    tbl.push_back(mk(1, 16'h005A, 5'd7, 0, 0, 0, 1, 0, 4'd0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, 16'h0, 5'd0, 0, 1, s[11-i], 0, (i == 6),
                       (i < 6) ? 4'd0 : 4'd1, 0));
    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].v, tbl[i].d, tbl[i].clr);
      check("tbl_flag", int'(flag), int'(tbl[i].ef));
      check("tbl_cnt", int'(match_cnt), int'(tbl[i].ec));
      check("tbl_err", int'(cfg_err), int'(tbl[i].ee));
    end

    // Full-length pattern with a gap in the middle.
    p = 16'hA5C3;
    step(1, p, 5'd16, 1, 0, 0, 1);
    pulses = 0;
    for (int i = 15; i >= 0; i--) begin
      bit_in(p[i]);
      if (i == 11)
        repeat (3) step(0, '0, '0, 0, 0, 1'($urandom), 0);
    end
    check("full_last_flag", int'(flag), 1);
    check("full_pulses", pulses, 1);

    // Reload before the last bit discards the partial history.
    step(1, 16'h0005, 5'd3, 1, 0, 0, 0);
    bit_in(1); bit_in(0);
    pulses = 0;
    step(1, 16'h0005, 5'd3, 1, 1, 1, 0);
    check("reload_flag", int'(flag), 0);
    bit_in(1);
    check("reload_hist_clear", pulses, 0);
    bit_in(0); bit_in(1);
    check("reload_then_match", int'(flag), 1);
    step(1, 16'($urandom), 5'd0, 1, 0, 0, 0);
    check("len0_err", int'(cfg_err), 1);
    pulses = 0;
    repeat (20) bit_in(1'($urandom));
    check("len0_pulses", pulses, 0);
    step(1, 16'hFFFF, 5'd17, 1, 0, 0, 0);
    check("len17_err", int'(cfg_err), 1);
    repeat (20) bit_in(1'b1);
    check("len17_pulses", pulses, 0);

    // Counter saturation with a single-bit pattern.
    step(1, 16'h0001, 5'd1, 1, 0, 0, 1);
    pulses = 0;
    repeat (20) bit_in(1);
    check("sat_pulses", pulses, 20);
    check("sat_cnt", int'(match_cnt), 15);
    check("sat_flag", int'(cnt_sat), 1);
    step(0, '0, '0, 0, 1, 1, 1);
    check("clr_match_cnt", int'(match_cnt), 1);
    check("clr_match_sat", int'(cnt_sat), 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4)
        step(1, 16'($urandom), 5'($urandom_range(0, 18) < 16 ? $urandom_range(1, 4)
                                                          : $urandom_range(0, 20)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
      else
        step(0, '0, '0, 0, 1'($urandom_range(0, 9) < 8), 1'($urandom),
             1'($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset in the middle of the stream.
    step(1, 16'h0005, 5'd3, 1, 0, 0, 1);
    bit_in(1); bit_in(0); bit_in(1);
    check("pre_rst_flag", int'(flag), 1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_flag", int'(flag), 0);
    check("arst_cnt", int'(match_cnt), 0);
    check("arst_sat", int'(cnt_sat), 0);
    check("arst_err", int'(cfg_err), 1);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    check("post_rst_pulses", pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
